// File: rtl/sd_cmd_frame_receiver.sv
`default_nettype none
// ============================================================================
// Module      : sd_cmd_frame_receiver
// Description : Assembles 6-byte SD command frames from an SPI byte stream,
//               checks end bit / CRC7, tracks the APP_CMD prefix and queues
//               good commands in a small FIFO for the consumer.
// Revision    : 1.0 - initial release
// ============================================================================
module sd_cmd_frame_receiver #(
    parameter int CRC_EN  = 1,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  io_InputBuffer,
    input  logic        io_BufferChanged,
    input  logic        io_CmdReady,
    output logic        io_CmdValid,
    output logic [5:0]  io_Command,
    output logic [31:0] io_CommandArgument,
    output logic        io_IsAppCmd,
    output logic        io_CrcError,
    output logic        io_FrameError,
    output logic        io_Overflow,
    output logic        io_Busy
);
    localparam int AW = (DEPTH < 2) ? 1 : $clog2(DEPTH);
    localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
    localparam int EW = 39;   // {is_app, index[5:0], argument[31:0]}

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARG  = 2'd1,
        CRC  = 2'd2
    } state_t;

    // CRC7 (x^7 + x^3 + 1) advanced over one byte, MSB first
    function automatic logic [6:0] crc7_byte(input logic [6:0] crc_in, input logic [7:0] data);
        logic [6:0] c;
        logic       fb;
        c = crc_in;
        for (int i = 7; i >= 0; i--) begin
            fb = c[6] ^ data[i];
            c  = {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
        end
        return c;
    endfunction

    state_t          state_q, state_d;
    logic [5:0]      idx_q, idx_d;
    logic [31:0]     arg_q, arg_d;
    logic [6:0]      crc_q, crc_d;
    logic [1:0]      bcnt_q, bcnt_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic            app_q, app_d;
    logic            crc_err_q, crc_err_d;
    logic            frame_err_q, frame_err_d;
    logic            ovf_q;
    logic            good;

    logic [EW-1:0]   mem_q [DEPTH];
    logic [AW:0]     wr_q, rd_q;
    logic            empty, full, pop, push;
    logic [EW-1:0]   head;

    assign empty = (wr_q == rd_q);
    assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign pop   = !empty && io_CmdReady;
    // A full FIFO still takes the frame when the head leaves in the same cycle
    assign push  = good && (!full || pop);
    assign head  = mem_q[rd_q[AW-1:0]];

    // Frame FSM: next state, frame datapath and status pulses
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        arg_d       = arg_q;
        crc_d       = crc_q;
        bcnt_d      = bcnt_q;
        app_d       = app_q;
        crc_err_d   = 1'b0;
        frame_err_d = 1'b0;
        good        = 1'b0;
        case (state_q)
            IDLE: begin
                if (io_BufferChanged && io_InputBuffer[7:6] == 2'b01) begin
                    idx_d   = io_InputBuffer[5:0];
                    crc_d   = crc7_byte(7'd0, io_InputBuffer);
                    bcnt_d  = 2'd0;
                    state_d = ARG;
                end
            end
            ARG: begin
                if (io_BufferChanged) begin
                    arg_d  = {arg_q[23:0], io_InputBuffer};
                    crc_d  = crc7_byte(crc_q, io_InputBuffer);
                    bcnt_d = bcnt_q + 2'd1;
                    if (bcnt_q == 2'd3) begin
                        state_d = CRC;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    frame_err_d = 1'b1;
                    app_d       = 1'b0;
                    state_d     = IDLE;
                end
            end
            CRC: begin
                if (io_BufferChanged) begin
                    state_d = IDLE;
                    if (!io_InputBuffer[0]) begin
                        frame_err_d = 1'b1;
                        app_d       = 1'b0;
                    end else if ((CRC_EN != 0) && (io_InputBuffer[7:1] != crc_q)) begin
                        crc_err_d = 1'b1;
                        app_d     = 1'b0;
                    end else begin
                        good  = 1'b1;
                        app_d = (idx_q == 6'd55);
                    end
                end else if (tmo_q == TMO_LAST) begin
                    frame_err_d = 1'b1;
                    app_d       = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Inter-byte gap counter only runs while a frame is open
        if (io_BufferChanged || state_d == IDLE) begin
            tmo_d = '0;
        end else begin
            tmo_d = tmo_q + TW'(1);
        end
    end

    // FSM state register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Frame datapath, status flags and FIFO pointers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            idx_q       <= '0;
            arg_q       <= '0;
            crc_q       <= '0;
            bcnt_q      <= '0;
            tmo_q       <= '0;
            app_q       <= 1'b0;
            crc_err_q   <= 1'b0;
            frame_err_q <= 1'b0;
            ovf_q       <= 1'b0;
            wr_q        <= '0;
            rd_q        <= '0;
        end else begin
            idx_q       <= idx_d;
            arg_q       <= arg_d;
            crc_q       <= crc_d;
            bcnt_q      <= bcnt_d;
            tmo_q       <= tmo_d;
            app_q       <= app_d;
            crc_err_q   <= crc_err_d;
            frame_err_q <= frame_err_d;
            if (good && full && !pop) begin
                ovf_q <= 1'b1;
            end
            if (push) begin
                wr_q <= wr_q + 1'b1;
            end
            if (pop) begin
                rd_q <= rd_q + 1'b1;
            end
        end
    end

    // FIFO storage; contents are only observable through the valid-gated outputs
    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_q[AW-1:0]] <= {app_q, idx_q, arg_q};
        end
    end

    assign io_CmdValid        = !empty;
    assign io_Command         = empty ? 6'd0  : head[37:32];
    assign io_CommandArgument = empty ? 32'd0 : head[31:0];
    assign io_IsAppCmd        = empty ? 1'b0  : head[38];
    assign io_CrcError        = crc_err_q;
    assign io_FrameError      = frame_err_q;
    assign io_Overflow        = ovf_q;
    assign io_Busy            = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_sd_cmd_frame_receiver.sv
`default_nettype none
// ============================================================================
// Module      : tb_sd_cmd_frame_receiver
// Description : Self-checking bench; two instances (CRC checked / unchecked)
//               share one stimulus stream and are each compared every cycle
//               against a frame-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sd_cmd_frame_receiver;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 16;

    logic       clock     = 1'b0;
    logic       reset     = 1'b1;
    logic [7:0] in_byte   = 8'hFF;
    logic       strobe    = 1'b0;
    logic       cmd_ready = 1'b0;
    bit         rnd_mode  = 1'b0;
    int         d_chk     = 0;
    int         d_fail    = 0;

    always #5 clock = ~clock;

    // CRC7 as the remainder of M(x)*x^7 divided by x^7+x^3+1
    function automatic logic [6:0] crc7_div(input logic [39:0] msg);
        logic [46:0] r;
        r = {msg, 7'b0};
        for (int i = 46; i >= 7; i--) begin
            if (r[i]) r = r ^ (47'h89 << (i - 7));
        end
        return r[6:0];
    endfunction

    for (genvar k = 0; k < 2; k++) begin : g_inst
        localparam int CEN = (k == 0) ? 1 : 0;
        logic        valid, app, cerr, ferr, ovf, busy;
        logic [5:0]  cmd;
        logic [31:0] arg;
        int          n_chk  = 0;
        int          n_fail = 0;

        sd_cmd_frame_receiver #(
            .CRC_EN (CEN),
            .DEPTH  (DEPTH),
            .TIMEOUT(TIMEOUT)
        ) u_dut (
            .clock             (clock),
            .reset             (reset),
            .io_InputBuffer    (in_byte),
            .io_BufferChanged  (strobe),
            .io_CmdReady       (cmd_ready),
            .io_CmdValid       (valid),
            .io_Command        (cmd),
            .io_CommandArgument(arg),
            .io_IsAppCmd       (app),
            .io_CrcError       (cerr),
            .io_FrameError     (ferr),
            .io_Overflow       (ovf),
            .io_Busy           (busy)
        );

        // Reference: frame bytes collected in a queue, judged once six are in
        logic [7:0]  frame [$];
        logic [38:0] fifo  [$];
        int          idle   = 0;
        bit          flag   = 0;
        bit          m_ovf  = 0;
        bit          m_cerr = 0;
        bit          m_ferr = 0;

        initial begin : p_model
            bit          do_pop;
            bit          good;
            logic [38:0] entry;
            forever begin
                @(posedge clock or posedge reset);
                if (reset) begin
                    frame.delete();
                    fifo.delete();
                    idle = 0; flag = 0; m_ovf = 0; m_cerr = 0; m_ferr = 0;
                end else begin
                    do_pop = (fifo.size() > 0) && cmd_ready;
                    good   = 0;
                    entry  = '0;
                    m_cerr = 0;
                    m_ferr = 0;
                    if (strobe) begin
                        idle = 0;
                        if (frame.size() > 0 || in_byte[7:6] == 2'b01) frame.push_back(in_byte);
                        if (frame.size() == 6) begin
                            if (!frame[5][0]) m_ferr = 1;
                            else if (CEN != 0 && frame[5][7:1] !=
                                     crc7_div({frame[0], frame[1], frame[2], frame[3], frame[4]})) m_cerr = 1;
                            else begin
                                good  = 1;
                                entry = {flag, frame[0][5:0], frame[1], frame[2], frame[3], frame[4]};
                            end
                            if (!good) flag = 0;
                            frame.delete();
                        end
                    end else if (frame.size() > 0) begin
                        idle++;
                        if (idle == TIMEOUT) begin
                            m_ferr = 1; flag = 0; idle = 0;
                            frame.delete();
                        end
                    end
                    if (do_pop) void'(fifo.pop_front());
                    if (good) begin
                        if (fifo.size() < DEPTH) fifo.push_back(entry);
                        else m_ovf = 1;
                        flag = (entry[37:32] == 6'd55);
                    end
                end
            end
        end

        initial begin : p_cmp
            logic [43:0] got;
            logic [43:0] exp_v;
            logic [38:0] head;
            forever begin
                @(negedge clock);
                head  = (fifo.size() > 0) ? fifo[0] : 39'd0;
                exp_v = {fifo.size() > 0, head[37:32], head[31:0], head[38],
                         m_cerr, m_ferr, m_ovf, frame.size() > 0};
                got   = {valid, cmd, arg, app, cerr, ferr, ovf, busy};
                n_chk++;
                if (got !== exp_v) begin
                    n_fail++;
                    $display("FAIL outputs inst%0d t=%0t got=%h exp=%h (valid,cmd,arg,app,crcerr,frmerr,ovf,busy)",
                             k, $time, got, exp_v);
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp_v);
        d_chk++;
        if (got !== exp_v) begin
            d_fail++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        if (rnd_mode) cmd_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic send_byte(input logic [7:0] b);
        in_byte = b;
        strobe  = 1'b1;
        tick();
        strobe  = 1'b0;
        in_byte = 8'hFF;
    endtask

    task automatic send_raw(input logic [47:0] bytes);
        for (int i = 5; i >= 0; i--) send_byte(bytes[i*8 +: 8]);
    endtask

    task automatic send_frame(input logic [5:0] idx, input logic [31:0] a,
                              input bit bad_crc, input bit bad_end, input int maxgap);
        logic [39:0] m;
        logic [7:0]  last;
        m    = {2'b01, idx, a};
        last = {crc7_div(m) ^ (bad_crc ? 7'h01 : 7'h00), ~bad_end};
        for (int i = 4; i >= 0; i--) begin
            send_byte(m[i*8 +: 8]);
            repeat ($urandom_range(0, maxgap)) tick();
        end
        send_byte(last);
    endtask

    task automatic pop_one();
        cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0;
    endtask

    initial begin : p_stim
        int          kind;
        logic [5:0]  idx;
        logic [31:0] a;
        logic [7:0]  fill;
        int          total;
        int          fails;

        repeat (3) tick();
        check("reset_valid", 64'(g_inst[0].valid), 64'd0);
        check("reset_busy",  64'(g_inst[0].busy),  64'd0);
        reset = 1'b0;
        tick();

        check("model_crc_cmd0",   64'(crc7_div(40'h4000000000)), 64'h4A);
        check("model_crc_cmd8",   64'(crc7_div(40'h48000001AA)), 64'h43);
        check("model_crc_cmd55",  64'(crc7_div(40'h7700000000)), 64'h32);
        check("model_crc_acmd41", 64'(crc7_div(40'h6940000000)), 64'h3B);

        // CMD0: valid rises right after the final strobe
        for (int i = 0; i < 5; i++) send_byte((i == 0) ? 8'h40 : 8'h00);
        check("cmd0_valid_early", 64'(g_inst[0].valid), 64'd0);
        send_byte(8'h95);
        check("cmd0_valid", 64'(g_inst[0].valid), 64'd1);
        check("cmd0_cmd",   64'(g_inst[0].cmd),   64'd0);
        check("cmd0_arg",   64'(g_inst[0].arg),   64'd0);
        check("cmd0_app",   64'(g_inst[0].app),   64'd0);
        pop_one();

        send_raw(48'h48000001AA87);
        check("cmd8_cmd", 64'(g_inst[0].cmd), 64'd8);
        check("cmd8_arg", 64'(g_inst[0].arg), 64'h1AA);
        pop_one();

        send_raw(48'h400000000097);
        check("badcrc_pulse",      64'(g_inst[0].cerr),  64'd1);
        check("badcrc_no_entry",   64'(g_inst[0].valid), 64'd0);
        check("nocrc_accepted",    64'(g_inst[1].valid), 64'd1);
        check("nocrc_no_errpulse", 64'(g_inst[1].cerr),  64'd0);
        pop_one();

        send_raw(48'h770000000065);
        send_raw(48'h694000000077);
        check("cmd55_cmd", 64'(g_inst[0].cmd), 64'd55);
        check("cmd55_app", 64'(g_inst[0].app), 64'd0);
        pop_one();
        check("acmd41_cmd", 64'(g_inst[0].cmd), 64'd41);
        check("acmd41_arg", 64'(g_inst[0].arg), 64'h40000000);
        check("acmd41_app", 64'(g_inst[0].app), 64'd1);
        pop_one();
        send_frame(6'd16, 32'd512, 0, 0, 0);
        check("cmd16_cmd", 64'(g_inst[0].cmd), 64'd16);
        check("cmd16_app", 64'(g_inst[0].app), 64'd0);
        pop_one();

        // Five frames into a 4-deep FIFO with no consumer
        for (int i = 1; i <= 5; i++) send_frame(6'(i), 32'(i), 0, 0, 0);
        check("ovf_set", 64'(g_inst[0].ovf), 64'd1);
        for (int i = 1; i <= 4; i++) begin
            check("ovf_order_cmd", 64'(g_inst[0].cmd), 64'(i));
            check("ovf_order_arg", 64'(g_inst[0].arg), 64'(i));
            pop_one();
        end
        check("ovf_drained", 64'(g_inst[0].valid), 64'd0);

        // Stalled frame times out after exactly TIMEOUT idle cycles
        send_byte(8'h40);
        send_byte(8'h00);
        repeat (TIMEOUT - 1) tick();
        check("tmo_not_yet", 64'(g_inst[0].ferr), 64'd0);
        check("tmo_busy",    64'(g_inst[0].busy), 64'd1);
        tick();
        check("tmo_pulse", 64'(g_inst[0].ferr), 64'd1);
        check("tmo_idle",  64'(g_inst[0].busy), 64'd0);
        send_raw(48'h400000000095);
        check("after_tmo_valid", 64'(g_inst[0].valid), 64'd1);
        pop_one();

        // Reset mid-frame discards the partial frame
        send_byte(8'h40);
        send_byte(8'h00);
        send_byte(8'h00);
        reset = 1'b1;
        tick();
        check("rst_mid_valid", 64'(g_inst[0].valid), 64'd0);
        check("rst_mid_busy",  64'(g_inst[0].busy),  64'd0);
        reset = 1'b0;
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h95);
        check("rst_tail_ignored", 64'(g_inst[0].valid), 64'd0);
        send_raw(48'h400000000095);
        check("rst_fresh_frame", 64'(g_inst[0].valid), 64'd1);
        pop_one();

        // Randomized traffic: fill bytes, good/bad frames, gaps, back-pressure
        rnd_mode = 1'b1;
        for (int f = 0; f < 400; f++) begin
            kind = int'($urandom_range(0, 19));
            idx  = 6'($urandom);
            if ($urandom_range(0, 3) == 0) idx = 6'd55;
            a    = $urandom;
            repeat ($urandom_range(0, 2)) begin
                fill = 8'($urandom);
                if (fill[7:6] == 2'b01) fill[7] = 1'b1;
                send_byte(fill);
            end
            if (kind == 19) begin
                send_byte({2'b01, idx});
                send_byte(a[31:24]);
                reset = 1'b1;
                tick();
                reset = 1'b0;
            end else begin
                send_frame(idx, a, kind == 16, kind == 17, (kind == 18) ? TIMEOUT + 2 : 1);
            end
            repeat ($urandom_range(0, 3)) tick();
        end
        rnd_mode  = 1'b0;
        cmd_ready = 1'b1;
        repeat (DEPTH + 2) tick();
        cmd_ready = 1'b0;
        repeat (2) tick();

        total = d_chk + g_inst[0].n_chk + g_inst[1].n_chk;
        fails = d_fail + g_inst[0].n_fail + g_inst[1].n_fail;
        $display("[TB] %0d tests run, %0d failed", total, fails);
        $finish;
    end
endmodule
`default_nettype wire
